l1a_lct_match: RTL

L1A_LCT_MATCH -- requirements
Module: l1a_lct_match

---
 rtl/l1a_lct_match_pkg.sv | 39 +++
 rtl/cnt_en.sv | 68 ++++++
 rtl/match_fifo.sv | 76 +++++++
 rtl/l1a_lct_match.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/l1a_lct_match_pkg.sv
// -----------------------------------------------------------------------------
// l1a_lct_match_pkg
// Shared definitions for the L1A / LCT matcher:
//   - FSM state encoding of the match controller
//   - width of one match entry and the position of its two fields
//   - widths of the L1A number, drop counter and LCT history
//   - pack_entry(): assembles {L1A_NUM[11:0], PATTERN[4:0]}
// -----------------------------------------------------------------------------
package l1a_lct_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUSH    = 2'd2
  } state_e;

  localparam int LCT_W      = 5;    // LCTIN[5:1]
  localparam int HIST_DEPTH = 16;   // history taps 0..15
  localparam int L1A_NUM_W  = 24;
  localparam int DROP_W     = 8;
  localparam int WIN_W      = 4;    // window counter, POST up to 15

  // Match entry layout: {L1A_NUM[11:0], PATTERN[4:0]}
  localparam int PAT_LSB    = 0;
  localparam int PAT_W      = LCT_W;
  localparam int NUM_LSB    = PAT_LSB + PAT_W;
  localparam int NUM_W      = 12;
  localparam int ENTRY_W    = NUM_LSB + NUM_W;   // 17

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [NUM_W-1:0] num,
                                                    input logic [PAT_W-1:0] pat);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[NUM_LSB +: NUM_W] = num;
    e[PAT_LSB +: PAT_W] = pat;
    return e;
  endfunction

endpackage

// File: rtl/cnt_en.sv
// -----------------------------------------------------------------------------
// cnt_en
// Clock-enabled up-counter with synchronous clear and optional triple modular
// redundancy. The counter wraps naturally at 2**W.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   clr_i   : synchronous clear; with ce_i in the same cycle the result is 1
//   ce_i    : count enable
//   q_o     : current count (majority-voted when TMR != 0)
// -----------------------------------------------------------------------------
module cnt_en #(
  parameter int W   = 24,
  parameter int TMR = 0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         ce_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_v;

  // Every copy advances from the voted value so a single upset copy is
  // scrubbed on the next update.
  always_comb begin
    cnt_d = cnt_v;
    if (clr_i) begin
      cnt_d = ce_i ? W'(1) : '0;
    end else if (ce_i) begin
      cnt_d = cnt_v + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      logic [W-1:0] cnt_b_q;
      logic [W-1:0] cnt_c_q;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          cnt_b_q <= '0;
          cnt_c_q <= '0;
        end else begin
          cnt_b_q <= cnt_d;
          cnt_c_q <= cnt_d;
        end
      end

      assign cnt_v = (cnt_q & cnt_b_q) | (cnt_q & cnt_c_q) | (cnt_b_q & cnt_c_q);
    end else begin : g_single
      assign cnt_v = cnt_q;
    end
  endgenerate

  assign q_o = cnt_v;

endmodule

// File: rtl/match_fifo.sv
// -----------------------------------------------------------------------------
// match_fifo
// First-word-fall-through FIFO for match entries.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset (empties the FIFO)
//   wr_i    : write request; accepted when not full, or when full and a read
//             is popping in the same cycle
//   din_i   : write data
//   rd_i    : pop request; ignored while empty
//   dout_o  : head entry, forced to 0 while empty
//   full_o  : DEPTH entries held
//   empty_o : no entries held
// DEPTH must be a power of two (>= 2) so the pointers wrap on their own.
// -----------------------------------------------------------------------------
module match_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q,    cnt_d;
  logic             do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

  // A pop on a full FIFO frees the slot for a write in the same cycle.
  assign do_rd = rd_i & ~empty_o;
  assign do_wr = wr_i & (~full_o | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; the empty mask keeps stale words off dout_o.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/l1a_lct_match.sv
// -----------------------------------------------------------------------------
// l1a_lct_match
// Matches each accepted L1A against the LCT pulses in a window of PRE cycles
// before it (plus the L1A cycle itself) and POST cycles after it, then queues
// {L1A_NUM[11:0], PATTERN[4:0]} in a FWFT FIFO.
//   CLK      : system clock
//   RST_N    : asynchronous active-low reset, release synchronised internally
//   L1A      : one-cycle L1A pulse
//   LCTIN    : LCT pulses, bits [5:1] used, bit 0 (OR of the others) ignored
//   CNT_CLR  : synchronous clear of L1A_NUM, DROP_CNT and OVFL
//   RD       : pop FIFO head (ignored while DVALID=0)
//   DOUT     : FIFO head {L1A_NUM[11:0], PATTERN[4:0]}
//   DVALID   : FIFO not empty
//   L1A_NUM  : L1As seen since reset / clear (wraps)
//   DROP_CNT : L1As arriving while a match was in progress (saturates at 255)
//   OVFL     : sticky, a match entry was lost on a full FIFO
// -----------------------------------------------------------------------------
module l1a_lct_match
  import l1a_lct_match_pkg::*;
#(
  parameter int PRE    = 4,
  parameter int POST   = 4,
  parameter int FDEPTH = 8,
  parameter int TMR    = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 L1A,
  input  logic [5:0]           LCTIN,
  input  logic                 CNT_CLR,
  input  logic                 RD,
  output logic [ENTRY_W-1:0]   DOUT,
  output logic                 DVALID,
  output logic [L1A_NUM_W-1:0] L1A_NUM,
  output logic [DROP_W-1:0]    DROP_CNT,
  output logic                 OVFL
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // Reset synchroniser: assertion is immediate, release reaches the logic
  // only after two CLK edges.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  logic [LCT_W-1:0] lct;
  logic             lct_or_unused;

  assign lct           = LCTIN[5:1];
  assign lct_or_unused = LCTIN[0];

  // LCT history: tap k holds the LCTs seen k+1 cycles ago.
  logic [LCT_W-1:0] hist_q [HIST_DEPTH];
  logic [LCT_W-1:0] pre_or;

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      hist_q[0] <= lct;
      for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  always_comb begin
    pre_or = '0;
    for (int k = 0; k < PRE; k++) pre_or = pre_or | hist_q[k];
  end

  // L1A number counter
  logic [L1A_NUM_W-1:0] l1a_num;

  cnt_en #(
    .W   (L1A_NUM_W),
    .TMR (TMR)
  ) u_l1a_cnt (
    .clk_i   (CLK),
    .rst_n_i (rst_n_int),
    .clr_i   (CNT_CLR),
    .ce_i    (L1A),
    .q_o     (l1a_num)
  );

  assign L1A_NUM = l1a_num;

  // Match controller
  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q,   win_d;
  logic [PAT_W-1:0] pat_q,   pat_d;
  logic [NUM_W-1:0] num_q,   num_d;
  logic             push;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    pat_d   = pat_q;
    num_d   = num_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (L1A) begin
          pat_d   = pre_or | lct;
          num_d   = l1a_num[NUM_W-1:0];
          win_d   = WIN_W'(POST);
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        pat_d = pat_q | lct;
        win_d = win_q - WIN_W'(1);
        // win_q == 1 marks the last of the POST collection cycles.
        if (win_q == WIN_W'(1)) state_d = ST_PUSH;
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  // Entry payload is only consumed in PUSH, so it carries no reset.
  always_ff @(posedge CLK) begin
    pat_q <= pat_d;
    num_q <= num_d;
  end

  // Match FIFO
  logic fifo_full;
  logic fifo_empty;

  match_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (rst_n_int),
    .wr_i    (push),
    .din_i   (pack_entry(num_q, pat_q)),
    .rd_i    (RD),
    .dout_o  (DOUT),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign DVALID = ~fifo_empty;

  // Drop counter and overflow flag
  logic              dropped;
  logic              lost;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovfl_q, ovfl_d;

  assign dropped = L1A & (state_q != ST_IDLE);
  assign lost    = push & fifo_full & ~(RD & ~fifo_empty);

  always_comb begin
    drop_d = drop_q;
    ovfl_d = ovfl_q;
    if (CNT_CLR) begin
      drop_d = {{(DROP_W-1){1'b0}}, dropped};
      ovfl_d = 1'b0;
    end else if (dropped) begin
      drop_d = sat_inc(drop_q);
    end
    // A loss in the same cycle as a clear is still reported.
    if (lost) ovfl_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      drop_q <= '0;
      ovfl_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovfl_q <= ovfl_d;
    end
  end

  assign DROP_CNT = drop_q;
  assign OVFL     = ovfl_q;

endmodule
